// File: rtl/maxplus_acc.sv
// maxplus_acc: per-lane running maximum over a job of k_len partial max
// vectors, seeded with c_init. The result is held with backpressure until
// downstream takes it.
module maxplus_acc #(
  parameter int W     = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         k_len,
  input  logic [LANES*W-1:0] c_init,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [7:0]         cnt;
  logic [LANES*W-1:0] acc;
  logic [LANES*W-1:0] acc_max;
  logic               accept;

  assign accept = in_valid && (state == ACCUM);

  // Lane-wise unsigned max; a tie keeps the accumulator value.
  always_comb begin
    acc_max = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_max[i*W +: W] = (acc[i*W +: W] >= in_data[i*W +: W]) ?
                          acc[i*W +: W] : in_data[i*W +: W];
    end
  end

  // Job control FSM together with the accumulator and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= c_init;
            cnt   <= k_len;
            state <= (k_len != 8'd0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_max;
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign busy      = (state != IDLE);

endmodule

// File: doc/maxplus_acc.md
MAXPLUS_ACC -- requirements
Module: maxplus_acc

Interface
REQ-001 SHALL have parameter W, default 16, width of one unsigned lane value.
REQ-002 SHALL have parameter LANES, default 4, number of independent accumulator lanes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  job start request, sampled only in IDLE.
REQ-006 SHALL have port k_len  input  8  number of partial max vectors in the job, sampled with start.
REQ-007 SHALL have port c_init  input  LANES*W  initial accumulator vector, lane i at bits [i*W +: W], sampled with start.
REQ-008 SHALL have port in_valid  input  1  upstream max-tree result valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port in_data  input  LANES*W  partial max vector from the upstream reduction tree.
REQ-011 SHALL have port out_valid  output  1  final result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port out_data  output  LANES*W  final per-lane max vector.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-016 In IDLE with start=1: acc <= c_init, cnt <= k_len; next state ACCUM if k_len != 0, else DONE.
REQ-017 In IDLE with start=0: SHALL remain in IDLE with acc and cnt held.
REQ-018 in_ready SHALL be 1 exactly when state is ACCUM (registered state decode, no combinational path from in_valid).
REQ-019 On an accept (in_valid & in_ready), each lane SHALL update acc[i] <= (acc[i] >= in[i]) ? acc[i] : in[i], unsigned compare, ties keeping acc.
REQ-020 On an accept, cnt SHALL decrement by 1; if cnt was 1, next state SHALL be DONE.
REQ-021 In ACCUM with in_valid=0, acc, cnt and state SHALL hold; no timeout.
REQ-022 out_valid SHALL be 1 exactly when state is DONE; out_data SHALL equal acc and remain stable while out_valid=1.
REQ-023 In DONE, on out_ready=1 the next state SHALL be IDLE; otherwise DONE holds (backpressure, no data loss).
REQ-024 start SHALL be ignored in ACCUM and DONE; it is not queued.
REQ-025 Latency: final accept to out_valid=1 SHALL be exactly 1 cycle; start with k_len=0 to out_valid=1 SHALL be 1 cycle.
REQ-026 A new start SHALL be accepted in the cycle after the out_valid/out_ready handshake, giving a minimum job period of k_len+2 cycles.
REQ-027 No arithmetic overflow is possible; lane values SHALL never exceed the inputs seen.
REQ-028 in_data presented while in_ready=0 SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, acc all zeros, cnt 0, in_ready 0, out_valid 0, out_data 0, busy 0.
REQ-030 Reset asserted mid-job SHALL abort the job; no out_valid SHALL follow until a new start.
REQ-031 After reset deassertion, the first rising edge SHALL be able to accept start.

Verification
REQ-032 W=16, LANES=4: start, k_len=3, c_init={5,5,5,5}, inputs {1,9,5,0},{7,2,5,0},{3,3,6,0} -> out_data {7,9,6,5}, out_valid 1 cycle after the 3rd accept.
REQ-033 start with k_len=0, c_init={0xFFFF,0,1,2} -> out_valid next cycle, out_data {0xFFFF,0,1,2}, in_ready never 1.
REQ-034 k_len=2 with in_valid gapped (low 3 cycles between beats) -> cnt holds, exactly 2 accepts, correct max.
REQ-035 Result held with out_ready=0 for 5 cycles while start pulses -> out_data stable, start ignored, IDLE entered only after out_ready=1.
REQ-036 rst_n pulsed low after 1 of k_len=4 accepts -> all outputs 0 immediately, IDLE, no spurious out_valid; a subsequent job computes correctly.
REQ-037 Back-to-back jobs, start asserted the cycle after the output handshake -> second job accepted, period = k_len+2 cycles.
